state_update: RTL
=================

STATE_UPDATE -- requirements
Module: state_update

Interface
REQ-001 Parameter WORD_SIZE, default 32, data word width.
REQ-002 Parameter ADDRESS_WIDTH, default 16, memory address width.
REQ-003 Parameter FRAC_BITS, default 16, fractional bits of signed fixed-point data.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  request one Euler update pass; sampled only in IDLE.
REQ-007 step_in  input  WORD_SIZE  accepted step h (from step module step_out), latched on accepted start.
REQ-008 x_address  input  ADDRESS_WIDTH  base address of state vector x; latched on accepted start.
REQ-009 dx_address  input  ADDRESS_WIDTH  base address of derivative vector dx; latched on accepted start.
REQ-010 memory_read  output  1  single-port memory read strobe.
REQ-011 memory_write  output  1  single-port memory write strobe.
REQ-012 memory_address  output  ADDRESS_WIDTH  read/write address.
REQ-013 memory_data_in  input  WORD_SIZE  read data, valid the cycle after memory_read.
REQ-014 memory_data_out  output  WORD_SIZE  write data, valid while memory_write=1.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at pass completion.
REQ-017 overflow  output  1  sticky signed-overflow flag for the current/last pass.

Function
REQ-018 Pass SHALL compute x[i] <= x[i] + h*dx[i] for i = 0..n-1, n read from memory address 5.
REQ-019 States: IDLE, LOAD_N, LATCH_N, READ_X, READ_DX, CALC, WRITE, DONE.
REQ-020 IDLE: start=1 -> LOAD_N; latch step_in, x_address, dx_address; clear overflow; i<=0.
REQ-021 LOAD_N: memory_read=1, memory_address=5; -> LATCH_N.
REQ-022 LATCH_N: n<=memory_data_in; n==0 -> DONE, else -> READ_X.
REQ-023 READ_X: memory_read=1, address=x_base+i; -> READ_DX.
REQ-024 READ_DX: x_reg<=memory_data_in; memory_read=1, address=dx_base+i; -> CALC.
REQ-025 CALC: prod_reg <= (x... dx=memory_data_in) signed h*dx full 2*WORD_SIZE product, arithmetic shift right FRAC_BITS, low WORD_SIZE bits kept; -> WRITE.
REQ-026 WRITE: memory_write=1, address=x_base+i, data=x_reg+prod_reg (two's-complement wrap); i<=i+1; i+1==n -> DONE, else -> READ_X.
REQ-027 DONE: done=1 for exactly this cycle; -> IDLE.
REQ-028 Latency: start accepted at edge k -> done high during cycle k+3+4n; n=0 -> cycle k+3, no writes.
REQ-029 memory_read and memory_write SHALL never be high in the same cycle; address/data SHALL be 0 when neither strobe is high.
REQ-030 Address arithmetic SHALL wrap modulo 2^ADDRESS_WIDTH.
REQ-031 n SHALL be treated unsigned; index comparison full WORD_SIZE.
REQ-032 overflow SHALL set when product truncation discards non-sign bits or the addition overflows signed range; held until next accepted start.
REQ-033 start while busy SHALL be ignored; start held high in DONE SHALL be accepted only on the following IDLE cycle.
REQ-034 step_in/base-address changes during a pass SHALL not affect that pass.

Reset
REQ-035 rst=1 at any edge SHALL force IDLE, regardless of state, including mid-pass.
REQ-036 After reset: busy=0, done=0, overflow=0, memory_read=0, memory_write=0, memory_address=0, memory_data_out=0, all internal registers 0.
REQ-037 A write in progress when rst is sampled SHALL not be issued in the following cycle; partial vector updates are not rolled back.

Structure
REQ-038 Shared package SHALL hold N_ADDRESS=5, default FRAC_BITS, and the state encoding.
REQ-039 One sub-module fx_multiply (combinational signed fixed-point multiply with overflow output) SHALL be instantiated in CALC path.

Verification
REQ-040 n=0 at addr 5, start -> done at cycle k+3, no memory_write, busy high 3 cycles.
REQ-041 n=2, h=0x00008000 (0.5), x={0x00010000,0x00020000}, dx={0x00020000,0xFFFE0000} -> x={0x00020000,0x00010000}, done at k+11, overflow=0.
REQ-042 n=1, h=0x7FFF0000, dx=0x7FFF0000 -> overflow=1, x stored as wrapped result; next start clears overflow.
REQ-043 rst asserted in CALC of element 1 (n=3) -> next cycle IDLE, all outputs 0, element 1 unwritten; new start runs full pass correctly.
REQ-044 x_address=0xFFFF, n=2 -> second access at address 0x0000.
REQ-045 start pulsed during busy and step_in changed mid-pass -> pass unaffected, single done pulse.

Source files
------------

// File: rtl/state_update_pkg.sv
// state_update_pkg: shared constants and FSM encoding for the Euler state updater.
package state_update_pkg;
    localparam int N_ADDRESS = 5;
    localparam int DEFAULT_FRAC_BITS = 16;
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_N, S_LATCH_N, S_READ_X, S_READ_DX, S_CALC, S_WRITE, S_DONE
    } state_t;
endpackage

// File: rtl/state_update_fx_multiply.sv
// fx_multiply: combinational signed fixed-point multiply, truncated to WORD_SIZE with overflow flag.
module fx_multiply #(
    parameter int WORD_SIZE = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic [WORD_SIZE-1:0] i_a,
    input  logic [WORD_SIZE-1:0] i_b,
    output logic [WORD_SIZE-1:0] o_p,
    output logic                 o_ovf
);
    logic signed [2*WORD_SIZE-1:0] w_full;
    logic signed [2*WORD_SIZE-1:0] w_shift;
    // Low 2W bits of the product are identical for signed and unsigned operands once sign-extended.
    assign w_full  = {{WORD_SIZE{i_a[WORD_SIZE-1]}}, i_a} * {{WORD_SIZE{i_b[WORD_SIZE-1]}}, i_b};
    assign w_shift = w_full >>> FRAC_BITS;
    assign o_p     = w_shift[WORD_SIZE-1:0];
    assign o_ovf   = !(&w_full[2*WORD_SIZE-1:FRAC_BITS+WORD_SIZE-1] || ~|w_full[2*WORD_SIZE-1:FRAC_BITS+WORD_SIZE-1]);
endmodule

// File: rtl/state_update.sv
// state_update: one explicit-Euler pass x[i] += h*dx[i] over a vector in single-port memory.
module state_update
    import state_update_pkg::*;
#(
    parameter int WORD_SIZE     = 32,
    parameter int ADDRESS_WIDTH = 16,
    parameter int FRAC_BITS     = DEFAULT_FRAC_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WORD_SIZE-1:0]     step_in,
    input  logic [ADDRESS_WIDTH-1:0] x_address,
    input  logic [ADDRESS_WIDTH-1:0] dx_address,
    output logic                     memory_read,
    output logic                     memory_write,
    output logic [ADDRESS_WIDTH-1:0] memory_address,
    input  logic [WORD_SIZE-1:0]     memory_data_in,
    output logic [WORD_SIZE-1:0]     memory_data_out,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);
    state_t r_state, w_next;
    logic [WORD_SIZE-1:0] r_h, r_n, r_i, r_x, r_prod;
    logic [ADDRESS_WIDTH-1:0] r_xb, r_dxb;
    logic r_ovf;
    logic [WORD_SIZE-1:0] w_mul, w_sum;
    logic w_mul_ovf, w_add_ovf, w_last;
    logic [ADDRESS_WIDTH-1:0] w_xa, w_dxa;

    fx_multiply #(.WORD_SIZE(WORD_SIZE), .FRAC_BITS(FRAC_BITS)) u_mul (
        .i_a(r_h),
        .i_b(memory_data_in),
        .o_p(w_mul),
        .o_ovf(w_mul_ovf)
    );

    assign w_sum     = r_x + r_prod;
    assign w_add_ovf = (r_x[WORD_SIZE-1] == r_prod[WORD_SIZE-1]) && (w_sum[WORD_SIZE-1] != r_x[WORD_SIZE-1]);
    assign w_last    = (r_i + WORD_SIZE'(1)) == r_n;
    assign w_xa      = r_xb + r_i[ADDRESS_WIDTH-1:0];
    assign w_dxa     = r_dxb + r_i[ADDRESS_WIDTH-1:0];
    assign busy      = r_state != S_IDLE;
    assign done      = r_state == S_DONE;
    assign overflow  = r_ovf;

    always_comb begin
        w_next          = r_state;
        memory_read     = 1'b0;
        memory_write    = 1'b0;
        memory_address  = '0;
        memory_data_out = '0;
        case (r_state)
            S_IDLE:    w_next = start ? S_LOAD_N : S_IDLE;
            S_LOAD_N: begin
                memory_read    = 1'b1;
                memory_address = ADDRESS_WIDTH'(N_ADDRESS);
                w_next         = S_LATCH_N;
            end
            S_LATCH_N: w_next = (memory_data_in == '0) ? S_DONE : S_READ_X;
            S_READ_X: begin
                memory_read    = 1'b1;
                memory_address = w_xa;
                w_next         = S_READ_DX;
            end
            S_READ_DX: begin
                memory_read    = 1'b1;
                memory_address = w_dxa;
                w_next         = S_CALC;
            end
            S_CALC:    w_next = S_WRITE;
            S_WRITE: begin
                memory_write    = 1'b1;
                memory_address  = w_xa;
                memory_data_out = w_sum;
                w_next          = w_last ? S_DONE : S_READ_X;
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_h     <= '0;
            r_n     <= '0;
            r_i     <= '0;
            r_x     <= '0;
            r_prod  <= '0;
            r_xb    <= '0;
            r_dxb   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (start) begin
                    r_h   <= step_in;
                    r_xb  <= x_address;
                    r_dxb <= dx_address;
                    r_ovf <= 1'b0;
                    r_i   <= '0;
                end
                S_LATCH_N: r_n <= memory_data_in;
                S_READ_DX: r_x <= memory_data_in;
                S_CALC: begin
                    r_prod <= w_mul;
                    r_ovf  <= r_ovf | w_mul_ovf;
                end
                S_WRITE: begin
                    r_i   <= r_i + WORD_SIZE'(1);
                    r_ovf <= r_ovf | w_add_ovf;
                end
                default: ;
            endcase
        end
    end
endmodule
